// File: rtl/fetch_queue.sv
// Fetch-to-Decode instruction queue: small circular FIFO of {pc, instr}.
// almost_full stalls Fetch one entry early; flush drops every entry.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       almost_full,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL = CW'(DEPTH - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_push;
  logic w_pop;
  logic [DATA_W-1:0] w_head;

  assign in_ready    = !reset && !flush && (r_count != FULL);
  assign out_valid   = (r_count != '0);
  assign almost_full = (r_count >= AFULL);
  assign count       = r_count;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  assign w_head    = r_mem[r_rd_ptr];
  assign out_pc    = w_head[63:32];
  assign out_instr = w_head[31:0];

  // Array has no reset; head data is qualified by out_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-based reference model checked every cycle,
// directed test-plan scenarios with literal expectations, then random traffic.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_ready;
  logic        almost_full;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready = 1'b0;
  logic [2:0]  count;

  int total = 0;
  int bad = 0;

  logic [63:0] q[$];
  bit acc = 0;
  int n;

  fetch_queue #(.DEPTH(DEPTH), .DATA_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .almost_full(almost_full), .out_valid(out_valid),
    .out_pc(out_pc), .out_instr(out_instr),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain queue updated from the inputs seen at each edge.
  always @(posedge clk) begin
    n = q.size();
    acc = 0;
    if (reset || flush) begin
      q.delete();
    end else begin
      if (n != 0 && out_ready) void'(q.pop_front());
      if (in_valid && n != DEPTH) begin
        q.push_back(in_data);
        acc = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_ready", in_ready,
        (!reset && !flush && q.size() != DEPTH));
    chk("m_valid", out_valid, q.size() != 0);
    chk("m_count", count, q.size());
    chk("m_afull", almost_full, q.size() >= DEPTH - 1);
    chk("a_cnt_le", count <= DEPTH, 1);
    if (q.size() != 0) begin
      chk("m_pc", out_pc, q[0][63:32]);
      chk("m_instr", out_instr, q[0][31:0]);
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic r, input logic f, input logic rs);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data = {pc, pc + 32'h13};
    out_ready = r;
    flush = f;
    reset = rs;
    @(negedge clk);
  endtask

  initial begin
    drive(0, 0, 0, 0, 1);
    chk("rst_ready", in_ready, 0);
    chk("rst_count", count, 0);
    // Reset then single word
    @(posedge clk);
    #1;
    reset = 0;
    in_valid = 1;
    in_data = 64'h00000004_00A00093;
    @(negedge clk);
    chk("rel_ready", in_ready, 1);
    chk("rel_valid", out_valid, 0);
    drive(0, 0, 0, 0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_pc", out_pc, 32'h4);
    chk("t1_instr", out_instr, 32'h00A00093);
    chk("t1_count", count, 1);
    chk("t1_afull", almost_full, 0);
    drive(0, 0, 1, 0, 0);
    // Fill to full
    drive(1, 0, 0, 0, 0);
    chk("t2_empty", count, 0);
    drive(1, 4, 0, 0, 0);
    drive(1, 8, 0, 0, 0);
    drive(1, 12, 0, 0, 0);
    chk("t2_c3", count, 3);
    chk("t2_af3", almost_full, 1);
    chk("t2_rdy3", in_ready, 1);
    drive(1, 32'h99, 0, 0, 0);
    chk("t2_c4", count, 4);
    chk("t2_rdy4", in_ready, 0);
    drive(0, 0, 1, 0, 0);
    chk("t2_hold4", count, 4);
    chk("t2_head", out_pc, 0);
    // Drain with wrap
    drive(0, 0, 1, 0, 0);
    chk("t3_c3", count, 3);
    chk("t3_pc4", out_pc, 4);
    drive(1, 16, 0, 0, 0);
    chk("t3_pc8a", out_pc, 8);
    drive(1, 20, 0, 0, 0);
    drive(0, 0, 1, 0, 0);
    chk("t3_c4", count, 4);
    chk("t3_pc8", out_pc, 8);
    drive(0, 0, 1, 0, 0);
    chk("t3_pc12", out_pc, 12);
    drive(0, 0, 1, 0, 0);
    chk("t3_pc16", out_pc, 16);
    drive(0, 0, 1, 0, 0);
    chk("t3_pc20", out_pc, 20);
    drive(0, 0, 0, 0, 0);
    chk("t3_c0", count, 0);
    chk("t3_v0", out_valid, 0);
    // Simultaneous push/pop at count=2
    drive(1, 32'h30, 0, 0, 0);
    drive(1, 32'h34, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h38 + 4 * i, 1, 0, 0);
      chk("t4_count", count, 2);
      chk("t4_pc", out_pc, 32'h30 + 4 * i);
    end
    drive(0, 0, 0, 0, 0);
    chk("t4_end_c", count, 2);
    chk("t4_end_pc", out_pc, 32'h44);
    // Flush mid-stream
    drive(1, 32'h50, 0, 0, 0);
    drive(1, 32'h60, 1, 1, 0);
    chk("t5_c3", count, 3);
    chk("t5_rdy", in_ready, 0);
    drive(1, 32'h100, 0, 0, 0);
    chk("t5_c0", count, 0);
    chk("t5_v0", out_valid, 0);
    drive(1, 32'h104, 0, 0, 0);
    chk("t5_c1", count, 1);
    chk("t5_pc", out_pc, 32'h100);
    // Reset while full
    drive(1, 32'h108, 0, 0, 0);
    drive(1, 32'h10C, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    chk("t6_full", count, 4);
    chk("t6_rdy", in_ready, 0);
    drive(0, 0, 0, 0, 0);
    chk("t6_c0", count, 0);
    chk("t6_v0", out_valid, 0);
    chk("t6_af0", almost_full, 0);
    chk("t6_rdy1", in_ready, 1);
    // Random traffic; producer holds a word until it is accepted
    in_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = {$urandom, $urandom};
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 40) == 0);
      reset = ($urandom_range(0, 80) == 0);
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
